// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and pattern types for the RGB test-pattern source.
// Defaults describe 640x480 @ 60 Hz with a 25.175 MHz pixel clock.
package vga_timing_pkg;

  localparam int H_DISPLAY_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_DISPLAY_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  localparam int H_TOTAL = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  // Width of the hpos/vpos counters; must hold H_TOTAL-1 and V_TOTAL-1.
  localparam int POS_W = 10;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_GRAD  = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_WHITE = 2'd3
  } pattern_mode_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

endpackage

// File: rtl/vga_sync_gen.sv
// Pixel/line counters and unregistered sync/visible decode for the VGA source.
// Decode outputs describe the current counter position; the caller registers them.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY = H_DISPLAY_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_DISPLAY = V_DISPLAY_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_en,
  output logic [POS_W-1:0] hpos,
  output logic [POS_W-1:0] vpos,
  output logic             hsync_raw,
  output logic             vsync_raw,
  output logic             visible_raw
);

  localparam int H_TOT = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOT = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [POS_W-1:0] H_LAST   = POS_W'(H_TOT - 1);
  localparam logic [POS_W-1:0] V_LAST   = POS_W'(V_TOT - 1);
  localparam logic [POS_W-1:0] H_VIS    = POS_W'(H_DISPLAY);
  localparam logic [POS_W-1:0] V_VIS    = POS_W'(V_DISPLAY);
  localparam logic [POS_W-1:0] HS_FIRST = POS_W'(H_DISPLAY + H_FRONT);
  localparam logic [POS_W-1:0] HS_LAST  = POS_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [POS_W-1:0] VS_FIRST = POS_W'(V_DISPLAY + V_FRONT);
  localparam logic [POS_W-1:0] VS_LAST  = POS_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [POS_W-1:0] hpos_q, hpos_d;
  logic [POS_W-1:0] vpos_q, vpos_d;

  // Next counter position: hold when disabled, wrap the column at line end and the row at frame end.
  always_comb begin
    hpos_d = hpos_q;
    vpos_d = vpos_q;
    if (pix_en) begin
      if (hpos_q == H_LAST) begin
        hpos_d = '0;
        vpos_d = (vpos_q == V_LAST) ? '0 : vpos_q + 1'b1;
      end else begin
        hpos_d = hpos_q + 1'b1;
      end
    end
  end

  // Counter state; reset returns to the top-left of a fresh frame immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hpos_q <= '0;
      vpos_q <= '0;
    end else begin
      hpos_q <= hpos_d;
      vpos_q <= vpos_d;
    end
  end

  // Position decode for the current counter value (active-low syncs).
  always_comb begin
    hsync_raw   = !((hpos_q >= HS_FIRST) && (hpos_q <= HS_LAST));
    vsync_raw   = !((vpos_q >= VS_FIRST) && (vpos_q <= VS_LAST));
    visible_raw = (hpos_q < H_VIS) && (vpos_q < V_VIS);
  end

  assign hpos = hpos_q;
  assign vpos = vpos_q;

endmodule

// File: rtl/vga_rgb_source.sv
// VGA test-pattern source: timing counters plus a one-stage registered pattern pipeline.
// Optional build macro VGA_PATTERN_ANIM_EN adds a frame counter that scrolls the
// bars and gradient patterns one pixel per frame; without it frame is tied to 0.
module vga_rgb_source
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY = H_DISPLAY_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_DISPLAY = V_DISPLAY_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_en,
  input  logic [1:0]       mode,
  output logic             hsync,
  output logic             vsync,
  output logic             visible,
  output logic [POS_W-1:0] hpos,
  output logic [POS_W-1:0] vpos,
  output logic [7:0]       dr,
  output logic [7:0]       dg,
  output logic [7:0]       db,
  output logic [7:0]       frame
);

  logic hsync_raw, vsync_raw, visible_raw;

  vga_sync_gen #(
    .H_DISPLAY (H_DISPLAY),
    .H_FRONT   (H_FRONT),
    .H_SYNC    (H_SYNC),
    .H_BACK    (H_BACK),
    .V_DISPLAY (V_DISPLAY),
    .V_FRONT   (V_FRONT),
    .V_SYNC    (V_SYNC),
    .V_BACK    (V_BACK)
  ) u_sync (
    .clk         (clk),
    .reset       (reset),
    .pix_en      (pix_en),
    .hpos        (hpos),
    .vpos        (vpos),
    .hsync_raw   (hsync_raw),
    .vsync_raw   (vsync_raw),
    .visible_raw (visible_raw)
  );

  // Pixel colour for one position. xs is the column already shifted by the scroll
  // offset; only bits [8:0] matter because bars use [8:6] and the gradient [7:0].
  function automatic rgb_t pattern_pixel(input pattern_mode_t m,
                                         input logic [8:0]    xs,
                                         input logic [7:0]    y,
                                         input logic          chk);
    rgb_t px;
    px = '0;
    case (m)
      PAT_BARS: begin
        px.r = {8{xs[8]}};
        px.g = {8{xs[7]}};
        px.b = {8{xs[6]}};
      end
      PAT_GRAD: begin
        px.r = xs[7:0];
        px.g = y;
        px.b = xs[7:0] ^ y;
      end
      PAT_CHECK: px = {24{chk}};
      PAT_WHITE: px = '1;
      default:   px = '0;
    endcase
    return px;
  endfunction

  // Scroll offset; the full offset is 10 bits but its top bit is always zero.
  logic [8:0] off;

`ifdef VGA_PATTERN_ANIM_EN
  localparam logic [POS_W-1:0] H_LAST = POS_W'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [POS_W-1:0] V_LAST = POS_W'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);

  logic [7:0] frame_q, frame_d;

  // Count frames on the enabled cycle that wraps both counters back to the origin.
  always_comb begin
    frame_d = frame_q;
    if (pix_en && (hpos == H_LAST) && (vpos == V_LAST)) begin
      frame_d = frame_q + 8'd1;
    end
  end

  // Frame counter state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_q <= '0;
    end else begin
      frame_q <= frame_d;
    end
  end

  assign frame = frame_q;
  assign off   = {1'b0, frame_q};
`else
  assign frame = '0;
  assign off   = '0;
`endif

  pattern_mode_t mode_q, mode_d, mode_eff;
  logic          frame_start;
  logic [8:0]    xs_p0;
  rgb_t          px_p0;

  // Stage p0: latch mode at the frame origin (the origin pixel already uses the new
  // mode) and compute the colour for the current counter position.
  always_comb begin
    frame_start = (hpos == '0) && (vpos == '0);
    mode_eff    = frame_start ? pattern_mode_t'(mode) : mode_q;
    mode_d      = mode_q;
    if (pix_en && frame_start) begin
      mode_d = pattern_mode_t'(mode);
    end
    xs_p0 = hpos[8:0] + off;
    px_p0 = visible_raw ? pattern_pixel(mode_eff, xs_p0, vpos[7:0], hpos[5] ^ vpos[5]) : '0;
  end

  // Mode register; a mid-frame change waits for the next frame origin.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q <= PAT_BARS;
    end else begin
      mode_q <= mode_d;
    end
  end

  logic hsync_p1_q, hsync_p1_d;
  logic vsync_p1_q, vsync_p1_d;
  logic vld_p1_q,   vld_p1_d;
  rgb_t px_p1_q,    px_p1_d;

  // Stage p1: register syncs, visible and colour together so they stay aligned.
  always_comb begin
    hsync_p1_d = hsync_p1_q;
    vsync_p1_d = vsync_p1_q;
    vld_p1_d   = vld_p1_q;
    px_p1_d    = px_p1_q;
    if (pix_en) begin
      hsync_p1_d = hsync_raw;
      vsync_p1_d = vsync_raw;
      vld_p1_d   = visible_raw;
      px_p1_d    = px_p0;
    end
  end

  // Output registers; reset shows idle syncs and black.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync_p1_q <= 1'b1;
      vsync_p1_q <= 1'b1;
      vld_p1_q   <= 1'b0;
      px_p1_q    <= '0;
    end else begin
      hsync_p1_q <= hsync_p1_d;
      vsync_p1_q <= vsync_p1_d;
      vld_p1_q   <= vld_p1_d;
      px_p1_q    <= px_p1_d;
    end
  end

  assign hsync   = hsync_p1_q;
  assign vsync   = vsync_p1_q;
  assign visible = vld_p1_q;
  assign dr      = px_p1_q.r;
  assign dg      = px_p1_q.g;
  assign db      = px_p1_q.b;

endmodule

// File: tb/tb_vga_rgb_source.sv
// Directed bench for vga_rgb_source. dut_a uses the default 640x480 timing for
// line-level checks; dut_b uses a reduced 80x20 raster (64x12 visible) so
// frame-level behaviour is reached in a few thousand cycles.
module tb_vga_rgb_source;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, en_a, rst_b, en_b;
  logic [1:0] mode_a, mode_b;
  logic       hsync_a, vsync_a, visible_a, hsync_b, vsync_b, visible_b;
  logic [9:0] hpos_a, vpos_a, hpos_b, vpos_b;
  logic [7:0] dr_a, dg_a, db_a, frame_a, dr_b, dg_b, db_b, frame_b;

  vga_rgb_source dut_a (
    .clk(clk), .reset(rst_a), .pix_en(en_a), .mode(mode_a),
    .hsync(hsync_a), .vsync(vsync_a), .visible(visible_a),
    .hpos(hpos_a), .vpos(vpos_a), .dr(dr_a), .dg(dg_a), .db(db_a), .frame(frame_a)
  );

  vga_rgb_source #(
    .H_DISPLAY(64), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
    .V_DISPLAY(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(4)
  ) dut_b (
    .clk(clk), .reset(rst_b), .pix_en(en_b), .mode(mode_b),
    .hsync(hsync_b), .vsync(vsync_b), .visible(visible_b),
    .hpos(hpos_b), .vpos(vpos_b), .dr(dr_b), .dg(dg_b), .db(db_b), .frame(frame_b)
  );

`ifdef VGA_PATTERN_ANIM_EN
  localparam int FRAME_AFTER_ONE = 1;
`else
  localparam int FRAME_AFTER_ONE = 0;
`endif

  logic [54:0] snap_a, snap_prev;
  assign snap_a = {hsync_a, vsync_a, visible_a, hpos_a, vpos_a, dr_a, dg_a, db_a, frame_a};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int hs_low, hs_first, vs_low, vs_first_h, vs_first_v, changed;

  initial begin
    rst_a = 1'b1; en_a = 1'b1; mode_a = 2'd0;
    rst_b = 1'b1; en_b = 1'b1; mode_b = 2'd0;
    step(3);

    // Reset state
    check("rst_hpos",    32'(hpos_a), 32'd0);
    check("rst_vpos",    32'(vpos_a), 32'd0);
    check("rst_hsync",   32'(hsync_a), 32'd1);
    check("rst_vsync",   32'(vsync_a), 32'd1);
    check("rst_visible", 32'(visible_a), 32'd0);
    check("rst_rgb",     32'({dr_a, dg_a, db_a}), 32'd0);
    check("rst_frame",   32'(frame_a), 32'd0);

    // One line of mode 0: hsync window and bar colours (output describes hpos-1)
    rst_a = 1'b0;
    hs_low = 0; hs_first = -1;
    for (int i = 0; i < 800; i++) begin
      step(1);
      if (!hsync_a) begin
        if (hs_low == 0) hs_first = int'(hpos_a);
        hs_low++;
      end
      if (hpos_a == 10'd65)  check("bar_x64",  32'({dr_a, dg_a, db_a}), 32'h0000FF);
      if (hpos_a == 10'd449) check("bar_x448", 32'({dr_a, dg_a, db_a}), 32'hFFFFFF);
      if (hpos_a == 10'd701) check("bar_x700", 32'({dr_a, dg_a, db_a}), 32'h000000);
      if (hpos_a == 10'd640) check("vis_x639", 32'(visible_a), 32'd1);
      if (hpos_a == 10'd641) check("vis_x640", 32'(visible_a), 32'd0);
    end
    check("hs_low_cycles", 32'(hs_low), 32'd96);
    check("hs_first_hpos", 32'(hs_first), 32'd657);
    check("line_end_hpos", 32'(hpos_a), 32'd0);
    check("line_end_vpos", 32'(vpos_a), 32'd1);

    // pix_en at 50% for 1600 clocks: one line, nothing moves while disabled
    rst_a = 1'b1;
    step(1);
    rst_a = 1'b0;
    changed = 0;
    for (int i = 0; i < 1600; i++) begin
      en_a = (i % 2 == 0);
      snap_prev = snap_a;
      step(1);
      if (!en_a && (snap_a !== snap_prev)) changed++;
    end
    en_a = 1'b1;
    check("hold_changes", 32'(changed), 32'd0);
    check("toggle_hpos",  32'(hpos_a), 32'd0);
    check("toggle_vpos",  32'(vpos_a), 32'd1);

    // Asynchronous reset mid-line
    step(300);
    check("pre_rst_hpos", 32'(hpos_a), 32'd300);
    check("pre_rst_rgb",  32'({dr_a, dg_a, db_a}), 32'hFF0000);
    rst_a = 1'b1;
    #1;
    check("async_hpos",    32'(hpos_a), 32'd0);
    check("async_vpos",    32'(vpos_a), 32'd0);
    check("async_hsync",   32'(hsync_a), 32'd1);
    check("async_vsync",   32'(vsync_a), 32'd1);
    check("async_visible", 32'(visible_a), 32'd0);
    check("async_rgb",     32'({dr_a, dg_a, db_a}), 32'd0);
    check("async_frame",   32'(frame_a), 32'd0);
    step(1);
    rst_a = 1'b0;

    // Full frame on the reduced raster: vsync covers lines 14..15 = 160 cycles
    rst_b = 1'b0;
    vs_low = 0; vs_first_h = -1; vs_first_v = -1;
    for (int i = 0; i < 1600; i++) begin
      step(1);
      if (!vsync_b) begin
        if (vs_low == 0) begin
          vs_first_h = int'(hpos_b);
          vs_first_v = int'(vpos_b);
        end
        vs_low++;
      end
    end
    check("vs_low_cycles", 32'(vs_low), 32'd160);
    check("vs_first_hpos", 32'(vs_first_h), 32'd1);
    check("vs_first_vpos", 32'(vs_first_v), 32'd14);
    check("frame_end_hpos", 32'(hpos_b), 32'd0);
    check("frame_end_vpos", 32'(vpos_b), 32'd0);
    check("frame_count",    32'(frame_b), 32'(FRAME_AFTER_ONE));

    // Gradient: pixel (10,3) -> r=0A g=03 b=09
    rst_b = 1'b1; mode_b = 2'd1;
    step(1);
    rst_b = 1'b0;
    step(3 * 80 + 11);
    check("grad_10_3", 32'({dr_b, dg_b, db_b}), 32'h0A0309);

    // Mode 3 -> 2 mid-frame: stays white until the frame wraps, then checker
    rst_b = 1'b1; mode_b = 2'd3;
    step(1);
    rst_b = 1'b0;
    step(401);
    mode_b = 2'd2;
    step(80);
    check("white_0_6",  32'({dr_b, dg_b, db_b}), 32'hFFFFFF);
    step(400);
    check("white_0_11", 32'({dr_b, dg_b, db_b}), 32'hFFFFFF);
    step(720);
    check("chk_0_0",    32'({dr_b, dg_b, db_b}), 32'h000000);
    step(32);
    check("chk_32_0",   32'({dr_b, dg_b, db_b}), 32'hFFFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
